// File: rtl/mem_io_bridge_pkg.sv
// Shared constants for the cpu memory bridge: I/O page decode, register offsets,
// read-source encodings and a byte-select helper for the counter snapshot.
package mem_io_bridge_pkg;

  localparam logic [1:0] IO_BASE_HI  = 2'b11;
  localparam logic [2:0] IO_UART_OFS = 3'd0;
  localparam logic [2:0] IO_CNT_OFS  = 3'd4;

  localparam logic RD_SRC_IO  = 1'b0;
  localparam logic RD_SRC_RAM = 1'b1;

  function automatic logic [7:0] cnt_byte(input logic [31:0] val, input logic [1:0] idx);
    return val[8*idx +: 8];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a pop in the same cycle frees the slot
// for a push even when full.
module sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/mem_io_bridge.sv
// Decodes the cpu byte bus into block RAM or the I/O page (UART RX/TX, cycle counter,
// stop port) and returns read data one cycle after each request.
module mem_io_bridge
  import mem_io_bridge_pkg::*;
#(
  parameter int unsigned RAM_ADDR_WIDTH = 17,
  parameter int unsigned TX_FIFO_DEPTH  = 8,
  parameter int unsigned FULL_MARGIN    = 2,
  parameter logic [31:0] CNT_INIT       = 32'h0
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [31:0]               mem_a,
  input  logic                      mem_wr,
  input  logic [7:0]                mem_dout,
  output logic [7:0]                mem_din,
  output logic                      io_buffer_full,
  output logic                      ram_en,
  output logic                      ram_wr,
  output logic [RAM_ADDR_WIDTH-1:0] ram_a,
  output logic [7:0]                ram_wdata,
  input  logic [7:0]                ram_rdata,
  input  logic                      rx_empty,
  input  logic [7:0]                rx_data,
  output logic                      rx_rd,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      program_finish,
  output logic                      finish_done,
  output logic                      tx_overflow
);

  localparam int unsigned CNT_W = $clog2(TX_FIFO_DEPTH) + 1;

  logic             is_io, uart_wr, stop_wr;
  logic [2:0]       io_ofs;
  logic             tx_push, tx_pop, tx_push_ok, tx_full, tx_empty;
  logic [7:0]       tx_wdata;
  logic [CNT_W-1:0] tx_count, tx_count_nxt;
  logic             rd_src_q, rd_src_d;
  logic [7:0]       io_rd_q, io_rd_d;
  logic [31:0]      cnt_q, cnt_snap_q, cnt_snap_d;
  logic             finish_q, ovf_q, full_q;
  logic             unused_addr;

  assign unused_addr = ^mem_a[31:18];

  assign is_io  = (mem_a[17:16] == IO_BASE_HI);
  assign io_ofs = mem_a[2:0];

  // Strobes are gated so nothing reaches RAM or the UART while held in reset.
  assign ram_en    = rst_in & ~is_io;
  assign ram_wr    = ram_en & mem_wr;
  assign ram_a     = mem_a[RAM_ADDR_WIDTH-1:0];
  assign ram_wdata = mem_dout;
  assign rx_rd     = rst_in & is_io & ~mem_wr & (io_ofs == IO_UART_OFS) & ~rx_empty;

  assign uart_wr  = is_io & mem_wr & (io_ofs == IO_UART_OFS) & (mem_dout != 8'h00);
  assign stop_wr  = is_io & mem_wr & (io_ofs == IO_CNT_OFS);
  assign tx_push  = uart_wr | stop_wr;
  assign tx_wdata = stop_wr ? 8'h00 : mem_dout;
  assign tx_pop   = tx_valid & tx_ready;

  assign tx_push_ok   = tx_push & (~tx_full | tx_pop);
  assign tx_count_nxt = tx_count + CNT_W'(tx_push_ok) - CNT_W'(tx_pop);

  sync_fifo #(
    .DATA_W (8),
    .DEPTH  (TX_FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk_in),
    .rst_n (rst_in),
    .push  (tx_push),
    .wdata (tx_wdata),
    .pop   (tx_pop),
    .rdata (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  always_comb begin
    rd_src_d   = rd_src_q;
    io_rd_d    = io_rd_q;
    cnt_snap_d = cnt_snap_q;
    if (!mem_wr) begin
      if (is_io) begin
        rd_src_d = RD_SRC_IO;
        case (io_ofs)
          IO_UART_OFS: io_rd_d = rx_empty ? 8'h00 : rx_data;
          IO_CNT_OFS: begin
            io_rd_d    = cnt_q[7:0];
            cnt_snap_d = cnt_q;
          end
          3'd5, 3'd6, 3'd7: io_rd_d = cnt_byte(cnt_snap_q, io_ofs[1:0]);
          default:          io_rd_d = 8'h00;
        endcase
      end else begin
        rd_src_d = RD_SRC_RAM;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_src_q   <= RD_SRC_IO;
      io_rd_q    <= 8'h00;
      cnt_snap_q <= '0;
      cnt_q      <= CNT_INIT;
      finish_q   <= 1'b0;
      ovf_q      <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      rd_src_q   <= rd_src_d;
      io_rd_q    <= io_rd_d;
      cnt_snap_q <= cnt_snap_d;
      cnt_q      <= cnt_q + 32'd1;
      finish_q   <= finish_q | stop_wr;
      ovf_q      <= ovf_q | (tx_push & ~tx_push_ok);
      full_q     <= (CNT_W'(TX_FIFO_DEPTH) - tx_count_nxt) <= CNT_W'(FULL_MARGIN);
    end
  end

  assign mem_din        = (rd_src_q == RD_SRC_RAM) ? ram_rdata : io_rd_q;
  assign tx_valid       = ~tx_empty;
  assign io_buffer_full = full_q;
  assign program_finish = finish_q;
  assign finish_done    = finish_q & tx_empty & ~tx_valid;
  assign tx_overflow    = ovf_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Randomized bench for mem_io_bridge against a queue/array reference model, with
// directed RAM, UART, FIFO-fill, counter-wrap, stop-port and async-reset sequences.
module tb_mem_io_bridge;

  localparam int unsigned DEPTH    = 8;
  localparam int unsigned MARGIN   = 2;
  localparam logic [31:0] CNT_INIT = 32'hFFFF_FFFE;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [31:0] mem_a = '0;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_dout = '0;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic        ram_en, ram_wr;
  logic [16:0] ram_a;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        rx_empty = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_rd;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        program_finish, finish_done, tx_overflow;

  always #5 clk_in = ~clk_in;

  mem_io_bridge #(
    .RAM_ADDR_WIDTH (17),
    .TX_FIFO_DEPTH  (DEPTH),
    .FULL_MARGIN    (MARGIN),
    .CNT_INIT       (CNT_INIT)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .mem_dout       (mem_dout),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .ram_en         (ram_en),
    .ram_wr         (ram_wr),
    .ram_a          (ram_a),
    .ram_wdata      (ram_wdata),
    .ram_rdata      (ram_rdata),
    .rx_empty       (rx_empty),
    .rx_data        (rx_data),
    .rx_rd          (rx_rd),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .program_finish (program_finish),
    .finish_done    (finish_done),
    .tx_overflow    (tx_overflow)
  );

  // External synchronous RAM (256-byte window, aliased on low address bits).
  logic [7:0] ram_mem [256];
  always @(posedge clk_in) begin
    if (ram_en) begin
      if (ram_wr) ram_mem[ram_a[7:0]] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_a[7:0]];
    end
  end

  // Reference model state
  logic [7:0]  tx_q [$];
  logic [7:0]  ref_mem [256];
  logic [7:0]  exp_din;
  logic        m_finish, m_ovf;
  logic [31:0] m_cnt, m_snap;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    tx_q.delete();
    exp_din  = 8'h00;
    m_finish = 1'b0;
    m_ovf    = 1'b0;
    m_cnt    = CNT_INIT;
    m_snap   = '0;
  endtask

  task automatic check_regs();
    check_eq("mem_din", mem_din, exp_din);
    check_eq("tx_valid", tx_valid, tx_q.size() != 0);
    if (tx_q.size() != 0) check_eq("tx_data", tx_data, tx_q[0]);
    check_eq("io_buffer_full", io_buffer_full, (DEPTH - tx_q.size()) <= MARGIN);
    check_eq("program_finish", program_finish, m_finish);
    check_eq("tx_overflow", tx_overflow, m_ovf);
    check_eq("finish_done", finish_done, m_finish && tx_q.size() == 0);
  endtask

  // One request cycle: drive, check combinational strobes, advance model, clock, check regs.
  task automatic step(input logic [31:0] a, input logic wr, input logic [7:0] d,
                      input logic rxe, input logic [7:0] rxd, input logic txr);
    logic       is_io;
    logic [2:0] ofs;
    logic [7:0] nd;
    logic       pop;
    mem_a = a; mem_wr = wr; mem_dout = d; rx_empty = rxe; rx_data = rxd; tx_ready = txr;
    #1;
    is_io = (a[17:16] == 2'b11);
    ofs   = a[2:0];
    check_eq("ram_en", ram_en, !is_io);
    check_eq("ram_wr", ram_wr, !is_io && wr);
    check_eq("ram_a", ram_a, a[16:0]);
    check_eq("ram_wdata", ram_wdata, d);
    check_eq("rx_rd", rx_rd, is_io && !wr && ofs == 3'd0 && !rxe);

    nd  = exp_din;
    pop = (tx_q.size() != 0) && txr;
    if (!wr) begin
      if (!is_io) nd = ref_mem[a[7:0]];
      else begin
        case (ofs)
          3'd0: nd = rxe ? 8'h00 : rxd;
          3'd4: begin nd = m_cnt[7:0]; m_snap = m_cnt; end
          3'd5: nd = m_snap[15:8];
          3'd6: nd = m_snap[23:16];
          3'd7: nd = m_snap[31:24];
          default: nd = 8'h00;
        endcase
      end
    end else if (!is_io) begin
      ref_mem[a[7:0]] = d;
    end
    if (pop) void'(tx_q.pop_front());
    if (wr && is_io && ((ofs == 3'd0 && d != 8'h00) || ofs == 3'd4)) begin
      if (ofs == 3'd4) m_finish = 1'b1;
      if (tx_q.size() < DEPTH) tx_q.push_back(ofs == 3'd4 ? 8'h00 : d);
      else m_ovf = 1'b1;
    end
    exp_din = nd;
    m_cnt   = m_cnt + 32'd1;

    @(posedge clk_in);
    #1;
    check_regs();
  endtask

  // Assert reset between edges with a UART read pending, check outputs, then release.
  task automatic do_reset();
    mem_a = 32'h0003_0000; mem_wr = 1'b0; rx_empty = 1'b0; rx_data = 8'h5A; tx_ready = 1'b1;
    #2 rst_in = 1'b0;
    #1;
    check_eq("rst_mem_din", mem_din, 0);
    check_eq("rst_tx_valid", tx_valid, 0);
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_full", io_buffer_full, 0);
    check_eq("rst_finish", program_finish, 0);
    check_eq("rst_done", finish_done, 0);
    check_eq("rst_ovf", tx_overflow, 0);
    check_eq("rst_rx_rd", rx_rd, 0);
    check_eq("rst_ram_en", ram_en, 0);
    check_eq("rst_ram_wr", ram_wr, 0);
    model_reset();
    @(posedge clk_in);
    #3 rst_in = 1'b1;
    #1;
    check_regs();
  endtask

  initial begin
    logic [31:0] r, a;
    logic [7:0]  d;
    int          drained;
    model_reset();
    do_reset();

    // Counter snapshot across the 0xFFFFFFFF -> 0 wrap
    step(32'h0003_0004, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
    check_eq("cnt_b0", mem_din, 8'hFE);
    step(32'h0003_0005, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
    check_eq("cnt_b1", mem_din, 8'hFF);
    step(32'h0003_0006, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
    step(32'h0003_0007, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
    check_eq("cnt_b3", mem_din, 8'hFF);
    step(32'h0003_0004, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
    check_eq("cnt_wrapped", mem_din, 8'h02);

    // Fill the RAM window so every later read has a known value
    for (int i = 0; i < 256; i++) begin
      r = $urandom();
      a = {15'h0, r[16:8], 8'(i)};
      step(a, 1'b1, r[7:0], 1'b1, 8'h00, 1'b0);
    end

    step(32'h0000_0123, 1'b1, 8'hA5, 1'b1, 8'h00, 1'b0);
    step(32'h0000_0123, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
    check_eq("ram_rd_a5", mem_din, 8'hA5);

    step(32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h41, 1'b0);
    check_eq("uart_rd_41", mem_din, 8'h41);
    step(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h41, 1'b0);
    check_eq("uart_rd_empty", mem_din, 8'h00);

    // Fill the TX FIFO with the transmitter stalled
    for (int i = 0; i < 6; i++) begin
      step(32'h0003_0000, 1'b1, 8'h61 + 8'(i), 1'b1, 8'h00, 1'b0);
      check_eq("fill_full", io_buffer_full, i == 5);
    end
    step(32'h0003_0000, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) step(32'h0003_0000, 1'b1, 8'h67 + 8'(i), 1'b1, 8'h00, 1'b0);
    check_eq("overflow_set", tx_overflow, 1'b1);

    // Stop port with two bytes queued, then drain
    do_reset();
    step(32'h0003_0000, 1'b1, 8'h78, 1'b1, 8'h00, 1'b0);
    step(32'h0003_0000, 1'b1, 8'h79, 1'b1, 8'h00, 1'b0);
    step(32'h0003_0004, 1'b1, 8'h33, 1'b1, 8'h00, 1'b1);
    check_eq("stop_finish", program_finish, 1'b1);
    drained = 0;
    while (tx_q.size() != 0 && drained < 10) begin
      step(32'h0003_0001, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1);
      drained++;
    end
    check_eq("drain_bound", drained < 10, 1'b1);
    check_eq("finish_done", finish_done, 1'b1);

    // Reset in the middle of a TX drain
    step(32'h0003_0000, 1'b1, 8'h31, 1'b1, 8'h00, 1'b0);
    step(32'h0003_0000, 1'b1, 8'h32, 1'b1, 8'h00, 1'b1);
    do_reset();

    for (int n = 0; n < 3000; n++) begin
      r = $urandom();
      if ($urandom_range(0, 9) < 5) begin
        a = r;
        if (a[17:16] == 2'b11) a[16] = 1'b0;
      end else begin
        a = {r[31:18], 2'b11, 13'h0, r[2:0]};
      end
      d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom());
      step(a, $urandom_range(0, 99) < 40, d, $urandom_range(0, 2) == 0, 8'($urandom()),
           $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 299) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
